// File: rtl/mutative_types.sv
// rtl/mutative_types.sv - shared types and defaults for the mutative cache reconfiguration logic
package mutative_types;
  localparam int SETS_DEF     = 16;
  localparam int MAX_WAYS_DEF = 8;

  typedef enum logic [1:0] {
    DM = 2'b00,
    W2 = 2'b01,
    W4 = 2'b10,
    W8 = 2'b11
  } setup_t;

  localparam setup_t RESET_SETUP_DEF = W4;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PROBE,
    CHECK,
    WB,
    INV,
    PLRU_CLR,
    COMMIT
  } reconfig_state_t;
endpackage

// File: rtl/mutative_walk_counter.sv
// rtl/mutative_walk_counter.sv - set/way walk counters for the reconfiguration flush
// Both counters wrap to zero on their last index, so no terminal compare is needed elsewhere.
module mutative_walk_counter #(
  parameter int SETS         = 16,
  parameter int MAX_WAYS     = 8,
  parameter int SET_IDX_BITS = $clog2(SETS),
  parameter int WAY_IDX_BITS = $clog2(MAX_WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    inc_way_i,
  input  logic                    inc_set_i,
  output logic [SET_IDX_BITS-1:0] set_o,
  output logic [WAY_IDX_BITS-1:0] way_o,
  output logic                    last_way_o,
  output logic                    last_set_o
);
  logic [SET_IDX_BITS-1:0] set_q, set_d;
  logic [WAY_IDX_BITS-1:0] way_q, way_d;

  assign last_way_o = (way_q == WAY_IDX_BITS'(MAX_WAYS - 1));
  assign last_set_o = (set_q == SET_IDX_BITS'(SETS - 1));
  assign set_o      = set_q;
  assign way_o      = way_q;

  always_comb begin
    set_d = set_q;
    way_d = way_q;
    if (clear_i) begin
      set_d = '0;
      way_d = '0;
    end else begin
      if (inc_way_i) way_d = last_way_o ? '0 : way_q + WAY_IDX_BITS'(1);
      if (inc_set_i) set_d = last_set_o ? '0 : set_q + SET_IDX_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q <= '0;
      way_q <= '0;
    end else begin
      set_q <= set_d;
      way_q <= way_d;
    end
  end
endmodule

// File: rtl/mutative_reconfig_ctrl.sv
// rtl/mutative_reconfig_ctrl.sv - sequences a run-time associativity change of the mutative cache
// Drains the CPU side, flushes/invalidates every physical line, clears PLRU, then commits the new setup.
module mutative_reconfig_ctrl
  import mutative_types::*;
#(
  parameter int         SETS         = SETS_DEF,
  parameter int         MAX_WAYS     = MAX_WAYS_DEF,
  parameter int         SET_IDX_BITS = $clog2(SETS),
  parameter int         WAY_IDX_BITS = $clog2(MAX_WAYS),
  parameter logic [1:0] RESET_SETUP  = 2'b10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_req_valid,
  input  logic [1:0]              cfg_req_setup,
  output logic                    cfg_req_ready,
  output logic [1:0]              setup,
  output logic                    stall_req,
  input  logic                    cache_busy,
  output logic                    walk_valid,
  output logic [SET_IDX_BITS-1:0] walk_set,
  output logic [WAY_IDX_BITS-1:0] walk_way,
  input  logic                    line_valid,
  input  logic                    line_dirty,
  output logic                    wb_req,
  input  logic                    wb_ack,
  output logic                    inv_we,
  output logic                    plru_clr,
  output logic                    cfg_done,
  output logic                    busy
);
  reconfig_state_t state_q, state_d;
  setup_t          setup_q, pending_q;
  logic            lv_q, ld_q;
  logic            cnt_clear, inc_way, inc_set, last_way, last_set;

  mutative_walk_counter #(
    .SETS        (SETS),
    .MAX_WAYS    (MAX_WAYS),
    .SET_IDX_BITS(SET_IDX_BITS),
    .WAY_IDX_BITS(WAY_IDX_BITS)
  ) u_walk_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clear),
    .inc_way_i (inc_way),
    .inc_set_i (inc_set),
    .set_o     (walk_set),
    .way_o     (walk_way),
    .last_way_o(last_way),
    .last_set_o(last_set)
  );

  assign setup = setup_q;

  always_comb begin
    state_d       = state_q;
    cfg_req_ready = 1'b0;
    stall_req     = 1'b1;
    busy          = 1'b1;
    walk_valid    = 1'b0;
    wb_req        = 1'b0;
    inv_we        = 1'b0;
    plru_clr      = 1'b0;
    cfg_done      = 1'b0;
    cnt_clear     = 1'b0;
    inc_way       = 1'b0;
    inc_set       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_req_ready = 1'b1;
        stall_req     = 1'b0;
        busy          = 1'b0;
        if (cfg_req_valid) state_d = (setup_t'(cfg_req_setup) == setup_q) ? COMMIT : DRAIN;
      end
      DRAIN: begin
        if (!cache_busy) begin
          cnt_clear = 1'b1;
          state_d   = PROBE;
        end
      end
      PROBE: begin
        walk_valid = 1'b1;
        state_d    = CHECK;
      end
      CHECK: state_d = (line_valid && line_dirty) ? WB : INV;
      WB: begin
        wb_req = 1'b1;
        if (wb_ack) state_d = INV;
      end
      INV: begin
        // Clean-but-valid lines still need invalidating; invalid lines get no write.
        inv_we  = lv_q;
        inc_way = 1'b1;
        state_d = last_way ? PLRU_CLR : PROBE;
      end
      PLRU_CLR: begin
        plru_clr = 1'b1;
        inc_set  = 1'b1;
        state_d  = last_set ? COMMIT : PROBE;
      end
      COMMIT: begin
        cfg_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      setup_q   <= setup_t'(RESET_SETUP);
      pending_q <= DM;
      lv_q      <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cfg_req_valid) pending_q <= setup_t'(cfg_req_setup);
      if (state_q == CHECK) begin
        lv_q <= line_valid;
        ld_q <= line_dirty;
      end
      if (state_q == COMMIT) setup_q <= pending_q;
    end
  end
endmodule

// File: tb/tb_mutative_reconfig_ctrl.sv
// tb/tb_mutative_reconfig_ctrl.sv - scoreboard bench for mutative_reconfig_ctrl
module tb_mutative_reconfig_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_req_valid;
  logic [1:0] cfg_req_setup;
  logic       cfg_req_ready;
  logic [1:0] setup;
  logic       stall_req;
  logic       cache_busy;
  logic       walk_valid;
  logic [3:0] walk_set;
  logic [2:0] walk_way;
  logic       line_valid;
  logic       line_dirty;
  logic       wb_req;
  logic       wb_ack;
  logic       inv_we;
  logic       plru_clr;
  logic       cfg_done;
  logic       busy;
  logic       dirty_mode;

  mutative_reconfig_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_req_valid(cfg_req_valid),
    .cfg_req_setup(cfg_req_setup),
    .cfg_req_ready(cfg_req_ready),
    .setup        (setup),
    .stall_req    (stall_req),
    .cache_busy   (cache_busy),
    .walk_valid   (walk_valid),
    .walk_set     (walk_set),
    .walk_way     (walk_way),
    .line_valid   (line_valid),
    .line_dirty   (line_dirty),
    .wb_req       (wb_req),
    .wb_ack       (wb_ack),
    .inv_we       (inv_we),
    .plru_clr     (plru_clr),
    .cfg_done     (cfg_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    int         n_walk;
    int         n_wb_rise;
    int         n_wb_cyc;
    int         n_inv;
    int         n_plru;
    logic [1:0] new_setup;
    int         line_set;
    int         line_way;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Only set 3 / way 5 holds a valid dirty line when dirty_mode is on.
  always_comb begin
    line_valid = dirty_mode && walk_set == 4'd3 && walk_way == 3'd5;
    line_dirty = line_valid;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int lat, input int nw, input int nwr, input int nwc,
                              input int ni, input int np, input logic [1:0] s,
                              input int ls, input int lw);
    exp_t e;
    e.lat = lat; e.n_walk = nw; e.n_wb_rise = nwr; e.n_wb_cyc = nwc;
    e.n_inv = ni; e.n_plru = np; e.new_setup = s; e.line_set = ls; e.line_way = lw;
    return e;
  endfunction

  // Writeback responder: wb_ack arrives 4 cycles after wb_req first rises.
  initial begin
    wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_req && !rst) begin
        repeat (4) @(posedge clk);
        #1 wb_ack = 1'b1;
        @(posedge clk);
        #1 wb_ack = 1'b0;
      end
    end
  end

  // Monitor
  logic       active = 1'b0, chk_setup = 1'b0, wb_prev = 1'b0;
  logic [1:0] setup_exp;
  int acc_cyc, c_walk, c_wb_rise, c_wb_cyc, c_inv, c_plru, plru_next;
  int wb_s, wb_w, inv_s, inv_w;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0; chk_setup = 1'b0; wb_prev = 1'b0;
    end else begin
      if (chk_setup) begin
        chk("setup_after_commit", int'(setup), int'(setup_exp));
        chk_setup = 1'b0;
      end
      if (cfg_req_valid && cfg_req_ready) begin
        active = 1'b1; acc_cyc = cyc;
        c_walk = 0; c_wb_rise = 0; c_wb_cyc = 0; c_inv = 0; c_plru = 0; plru_next = 0;
        wb_s = -1; wb_w = -1; inv_s = -1; inv_w = -1; wb_prev = 1'b0;
      end else if (active) begin
        chk("strobe_onehot", int'($countones({walk_valid, wb_req, inv_we, plru_clr}) <= 1), 1);
        chk("stall_req_active", int'(stall_req), 1);
        if (walk_valid) c_walk++;
        if (wb_req) begin
          c_wb_cyc++;
          if (!wb_prev) begin c_wb_rise++; wb_s = int'(walk_set); wb_w = int'(walk_way); end
        end
        wb_prev = wb_req;
        if (inv_we) begin c_inv++; inv_s = int'(walk_set); inv_w = int'(walk_way); end
        if (plru_clr) begin
          chk("plru_set_order", int'(walk_set), plru_next);
          plru_next++; c_plru++;
        end
        if (cfg_done) begin
          active = 1'b0;
          if (sb_q.size() == 0) begin
            chk("unexpected_cfg_done", 1, 0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("latency", cyc - acc_cyc, e.lat);
            chk("walk_valid_count", c_walk, e.n_walk);
            chk("wb_req_rises", c_wb_rise, e.n_wb_rise);
            chk("wb_req_cycles", c_wb_cyc, e.n_wb_cyc);
            chk("inv_we_count", c_inv, e.n_inv);
            chk("plru_clr_count", c_plru, e.n_plru);
            if (e.line_set >= 0) begin
              chk("wb_set", wb_s, e.line_set);
              chk("wb_way", wb_w, e.line_way);
              chk("inv_set", inv_s, e.line_set);
              chk("inv_way", inv_w, e.line_way);
            end
            setup_exp = e.new_setup;
            chk_setup = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] s, input exp_t e);
    int t = 0;
    while (!cfg_req_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("ready_timeout", 0, 1);
    sb_q.push_back(e);
    cfg_req_valid = 1'b1;
    cfg_req_setup = s;
    @(posedge clk);
    #1 cfg_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb_q.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    if (t >= 3000) chk("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst = 1'b1; cfg_req_valid = 1'b0; cfg_req_setup = 2'b00;
    cache_busy = 1'b0; dirty_mode = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_setup", int'(setup), 2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stall", int'(stall_req), 0);
    chk("rst_strobes", int'({walk_valid, wb_req, inv_we, plru_clr, cfg_done}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", int'(cfg_req_ready), 1);

    // 10 -> 11, all lines invalid
    issue(2'b11, mk(402, 128, 0, 0, 0, 16, 2'b11, -1, -1));
    wait_done();

    // 11 -> 10 with cache_busy held for 5 cycles after acceptance
    issue(2'b10, mk(407, 128, 0, 0, 0, 16, 2'b10, -1, -1));
    cache_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 cache_busy = 1'b0;
    wait_done();

    // 10 -> 11 with one dirty line at set 3 way 5
    dirty_mode = 1'b1;
    issue(2'b11, mk(407, 128, 1, 5, 1, 16, 2'b11, 3, 5));
    wait_done();
    dirty_mode = 1'b0;

    // 11 -> 11: commit only
    issue(2'b11, mk(1, 0, 0, 0, 0, 0, 2'b11, -1, -1));
    wait_done();

    // Reset in the middle of a walk
    issue(2'b00, mk(402, 128, 0, 0, 0, 16, 2'b00, -1, -1));
    t = 0;
    while (t < 1000) begin
      @(negedge clk);
      if (walk_valid && walk_set == 4'd7) break;
      t++;
    end
    if (t >= 1000) chk("walk_set7_timeout", 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_setup", int'(setup), 2);
    chk("midrst_walk_set", int'(walk_set), 0);
    chk("midrst_walk_way", int'(walk_way), 0);
    chk("midrst_walk_valid", int'(walk_valid), 0);
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("midrst_ready", int'(cfg_req_ready), 1);
    issue(2'b01, mk(402, 128, 0, 0, 0, 16, 2'b01, -1, -1));
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
